// File: rtl/imem_program_loader.sv
// -----------------------------------------------------------------------------
// imem_program_loader
//
// Loads a program into the writable instruction RAM of the single-cycle core
// and otherwise passes core fetches through to the RAM read port.
//
// A load begins with load_start and a legal word_count. The program arrives
// as an 8-bit byte stream (valid/ready). Each group of three bytes is packed
// big-endian into one 22-bit instruction: {b0[5:0], b1, b2}. Words are written
// in order from index 0. The core is stalled for the whole load. After the
// last word, cpu_rst_n is held low for RST_CYCLES cycles so that the core
// restarts at PC 0.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   load_start  single-cycle pulse, starts a load (honoured in IDLE/ERR only)
//   word_count  number of words to load, sampled with load_start
//   byte_valid  byte stream valid
//   byte_data   byte stream data
//   byte_ready  loader accepts a byte this cycle
//   cpu_addr    core fetch byte address (PC)
//   cpu_instr   instruction to the core (zero while stalled or out of range)
//   cpu_stall   holds the core PC / regfile writes during a load
//   cpu_rst_n   active-low reset to the core, pulsed at the end of a load
//   mem_raddr   RAM read word index
//   mem_rdata   RAM combinational read data
//   mem_we      RAM write enable
//   mem_waddr   RAM write word index
//   mem_wdata   RAM write data
//   busy        load in progress
//   done        sticky, the last load completed
//   error       sticky, the last load_start had an illegal word_count
// -----------------------------------------------------------------------------
module imem_program_loader #(
  parameter int DEPTH      = 129,
  parameter int WORD_W     = 22,
  parameter int IDX_W      = 8,
  parameter int RST_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [IDX_W-1:0]  word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [21:0]       cpu_addr,
  output logic [WORD_W-1:0] cpu_instr,
  output logic              cpu_stall,
  output logic              cpu_rst_n,
  output logic [IDX_W-1:0]  mem_raddr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_waddr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_B0,
    S_B1,
    S_B2,
    S_WRITE,
    S_RELEASE,
    S_ERR
  } state_t;

  localparam int                RCNT_W    = $clog2(RST_CYCLES + 1);
  localparam logic [IDX_W:0]    DEPTH_L   = (IDX_W + 1)'(DEPTH);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RST_CYCLES - 1);

  state_t             state;
  state_t             next_state;
  logic [IDX_W-1:0]   count;
  logic [IDX_W-1:0]   index;
  logic [WORD_W-1:0]  asm_word;
  logic [RCNT_W-1:0]  rcnt;

  logic accept;
  logic load_ok;
  logic last_word;
  logic rel_last;

  assign accept    = byte_valid && byte_ready;
  assign load_ok   = (word_count != '0) && ({1'b0, word_count} <= DEPTH_L);
  assign last_word = (index == count - 1'b1);
  assign rel_last  = (rcnt == RCNT_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: next_state is given a default before the case so that every path
  // assigns it and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE, S_ERR: begin
        if (load_start) next_state = load_ok ? S_B0 : S_ERR;
      end
      S_B0:      if (accept) next_state = S_B1;
      S_B1:      if (accept) next_state = S_B2;
      S_B2:      if (accept) next_state = S_WRITE;
      S_WRITE:   next_state = last_word ? S_RELEASE : S_B0;
      S_RELEASE: if (rel_last) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (Moore, decoded from the state register)
  // ---------------------------------------------------------------------------
  always_comb begin
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b1;
    cpu_rst_n  = 1'b1;
    unique case (state)
      S_IDLE, S_ERR:    busy       = 1'b0;
      S_B0, S_B1, S_B2: byte_ready = 1'b1;
      S_WRITE:          mem_we     = 1'b1;
      S_RELEASE:        cpu_rst_n  = 1'b0;
      default:          busy       = 1'b0;
    endcase
  end

  assign cpu_stall = busy;
  assign mem_waddr = index;
  assign mem_wdata = asm_word;

  // ---------------------------------------------------------------------------
  // Datapath: load bookkeeping, byte packing, release counter, status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      index    <= '0;
      asm_word <= '0;
      rcnt     <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_ERR: begin
          if (load_start) begin
            done <= 1'b0;
            if (load_ok) begin
              count <= word_count;
              index <= '0;
              error <= 1'b0;
            end else begin
              error <= 1'b1;
            end
          end
        end
        // Big-endian packing; bits [7:6] of the first byte do not fit the
        // 22-bit word and are dropped.
        S_B0: if (accept) asm_word[21:16] <= byte_data[5:0];
        S_B1: if (accept) asm_word[15:8]  <= byte_data;
        S_B2: if (accept) asm_word[7:0]   <= byte_data;
        S_WRITE: begin
          rcnt <= '0;
          if (!last_word) index <= index + 1'b1;
        end
        S_RELEASE: begin
          rcnt <= rcnt + 1'b1;
          if (rel_last) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch path: word-aligned byte address into the RAM, NOP while stalled or
  // past the end of the RAM.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] fetch_idx;
  logic             unused_addr_bits;

  assign fetch_idx        = cpu_addr[IDX_W+1:2];
  assign mem_raddr        = fetch_idx;
  assign cpu_instr        = (!cpu_stall && ({1'b0, fetch_idx} < DEPTH_L)) ? mem_rdata : '0;
  assign unused_addr_bits = ^{cpu_addr[1:0], cpu_addr[21:IDX_W+2]};

endmodule

// File: tb/tb_imem_program_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_program_loader
//
// Self-checking bench for imem_program_loader. A behavioural RAM sits on the
// DUT memory ports. Each load computes the expected instruction words from
// the byte stream and pushes the expected RAM writes into a queue; a monitor
// pops and compares whenever mem_we is seen. A shadow image of the RAM
// contents (exp_ram) gives the expected fetch results.
// -----------------------------------------------------------------------------
module tb_imem_program_loader;

  localparam int DEPTH      = 129;
  localparam int WORD_W     = 22;
  localparam int IDX_W      = 8;
  localparam int RST_CYCLES = 4;

  logic              clk;
  logic              rst;
  logic              load_start;
  logic [IDX_W-1:0]  word_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic [21:0]       cpu_addr;
  logic [WORD_W-1:0] cpu_instr;
  logic              cpu_stall;
  logic              cpu_rst_n;
  logic [IDX_W-1:0]  mem_raddr;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [WORD_W-1:0] mem_wdata;
  logic              busy;
  logic              done;
  logic              error;

  imem_program_loader #(
    .DEPTH      (DEPTH),
    .WORD_W     (WORD_W),
    .IDX_W      (IDX_W),
    .RST_CYCLES (RST_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .cpu_addr   (cpu_addr),
    .cpu_instr  (cpu_instr),
    .cpu_stall  (cpu_stall),
    .cpu_rst_n  (cpu_rst_n),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: full 2^IDX_W entries so any read index is defined.
  logic [WORD_W-1:0] ram     [256];
  logic [WORD_W-1:0] exp_ram [256];

  assign mem_rdata = ram[mem_raddr];

  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_wdata;
  end

  // Scoreboard
  typedef struct {
    int          idx;
    logic [21:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stim_bytes[$];
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: every RAM write must match the head of the expected queue.
  always @(negedge clk) begin
    wr_t e;
    if (rst && mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(mem_waddr), 32'hffff_ffff);
      end else begin
        e = exp_q.pop_front();
        check("write_idx", 32'(mem_waddr), 32'(e.idx));
        check("write_data", 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  // Reference packing: three bytes -> one instruction, big-endian, top two
  // bits of the first byte dropped.
  function automatic logic [21:0] pack_word(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2);
    int v;
    v = (int'(b0) % 64) * 65536 + int'(b1) * 256 + int'(b2);
    return 22'(v);
  endfunction

  task automatic fill_random(input int n);
    stim_bytes.delete();
    for (int i = 0; i < 3 * n; i++) stim_bytes.push_back(8'($urandom));
  endtask

  task automatic fetch(input int addr);
    int          idx;
    logic [21:0] exp;
    @(negedge clk);
    cpu_addr = 22'(addr);
    #1;
    idx = (addr / 4) % 256;
    exp = (idx < DEPTH) ? exp_ram[idx] : 22'h0;
    check("fetch_raddr", 32'(mem_raddr), 32'(idx));
    check("fetch_instr", 32'(cpu_instr), 32'(exp));
  endtask

  // Runs one load of stim_bytes.size()/3 words.
  //   toggle   : byte_valid alternates 1/0 instead of being held high
  //   abort_at : assert rst once this many bytes were accepted (-1 = never)
  //   poke     : pulse an extra load_start mid-load
  task automatic run_load(input bit toggle, input int abort_at, input bit poke);
    int  n, nb, bi, cyc, rst_low, stall_drop, budget;
    bit  got_done, aborted;
    wr_t w;
    nb = stim_bytes.size();
    n  = nb / 3;
    for (int i = 0; i < n; i++) begin
      if (abort_at < 0 || (i + 1) * 3 < abort_at) begin
        w.idx  = i;
        w.data = pack_word(stim_bytes[3*i], stim_bytes[3*i+1], stim_bytes[3*i+2]);
        exp_q.push_back(w);
        exp_ram[i] = w.data;
      end
    end
    budget     = n * 12 + RST_CYCLES + 20;
    bi         = 0;
    cyc        = 0;
    rst_low    = 0;
    stall_drop = 0;
    got_done   = 0;
    aborted    = 0;

    @(negedge clk);
    load_start = 1'b1;
    word_count = 8'(n);
    @(posedge clk);
    while (!got_done && !aborted && cyc < budget) begin
      @(negedge clk);
      load_start = 1'b0;
      if (poke && cyc == 5) begin
        load_start = 1'b1;
        word_count = 8'd1;
      end
      if (cyc == 0) begin
        check("load_busy", 32'(busy), 32'd1);
        check("load_clears_error", 32'(error), 32'd0);
        check("load_clears_done", 32'(done), 32'd0);
      end
      if (cyc == 2) check("stall_nop", 32'(cpu_instr), 32'd0);
      if (done) begin
        got_done = 1;
      end else if (abort_at >= 0 && bi >= abort_at) begin
        rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_we", 32'(mem_we), 32'd0);
        check("abort_stall", 32'(cpu_stall), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        check("abort_waddr", 32'(mem_waddr), 32'd0);
        byte_valid = 1'b0;
        @(negedge clk);
        rst     = 1'b1;
        aborted = 1;
      end else begin
        if (!cpu_stall) stall_drop++;
        if (!cpu_rst_n) rst_low++;
        byte_data = 8'($urandom);
        if (bi < nb) begin
          byte_valid = toggle ? (cyc % 2 == 0) : 1'b1;
          byte_data  = stim_bytes[bi];
        end else begin
          byte_valid = 1'b0;
        end
        #1;
        if (byte_valid && byte_ready) bi++;
        cyc++;
      end
    end
    load_start = 1'b0;
    byte_valid = 1'b0;

    if (aborted) begin
      check("abort_pending_writes", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end else if (got_done) begin
      if (!toggle) check("load_cycles", 32'(cyc), 32'(4 * n + RST_CYCLES));
      check("rst_low_cycles", 32'(rst_low), 32'(RST_CYCLES));
      check("stall_held", 32'(stall_drop), 32'd0);
      check("idle_stall", 32'(cpu_stall), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
      check("pending_writes", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end else begin
      check("load_timeout", 32'(got_done), 32'd1);
      exp_q.delete();
    end
  endtask

  task automatic bad_start(input int cnt);
    @(negedge clk);
    load_start = 1'b1;
    word_count = 8'(cnt);
    @(negedge clk);
    load_start = 1'b0;
    check("err_flag", 32'(error), 32'd1);
    check("err_done", 32'(done), 32'd0);
    check("err_stall", 32'(cpu_stall), 32'd0);
    check("err_busy", 32'(busy), 32'd0);
    check("err_ready", 32'(byte_ready), 32'd0);
    byte_valid = 1'b1;
    byte_data  = 8'h5a;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    load_start = 1'b0;
    word_count = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    cpu_addr   = '0;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 22'($urandom);
      exp_ram[i] = ram[i];
    end
    ram[2]     = 22'h26_0088;
    exp_ram[2] = 22'h26_0088;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_waddr", 32'(mem_waddr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    rst = 1'b1;

    // Idle fetch pass-through
    fetch(8);
    check("idle_fetch_stall", 32'(cpu_stall), 32'd0);
    check("idle_fetch_busy", 32'(busy), 32'd0);

    // Directed two-word load, valid held high, stray load_start mid-load
    stim_bytes = '{8'h26, 8'h80, 8'h88, 8'h26, 8'h81, 8'h09};
    run_load(1'b0, -1, 1'b1);
    check("done_after_load", 32'(done), 32'd1);
    fetch(0);
    fetch(4);

    // Same load with byte_valid toggling
    stim_bytes = '{8'h26, 8'h80, 8'h88, 8'h26, 8'h81, 8'h09};
    run_load(1'b1, -1, 1'b0);
    fetch(5);

    // Illegal word counts, fetch while in ERR, then a legal load clears error
    bad_start(0);
    bad_start(130);
    fetch(8);
    fill_random(3);
    run_load(1'b0, -1, 1'b0);
    check("error_cleared", 32'(error), 32'd0);

    // Reset after the second byte of word 1 in a three-word load
    fill_random(3);
    run_load(1'b0, 5, 1'b0);
    check("post_abort_done", 32'(done), 32'd0);
    fetch(0);
    fetch(4);

    // Fetch range boundary
    fetch(516);
    fetch(512);
    fetch(1023);

    // Random loads
    for (int k = 0; k < 4; k++) begin
      fill_random(int'($urandom_range(1, 8)));
      run_load(1'($urandom_range(0, 1)), -1, 1'b0);
    end

    // Full-depth load
    fill_random(DEPTH);
    run_load(1'b0, -1, 1'b0);
    for (int k = 0; k < 20; k++) fetch(int'($urandom_range(0, 1023)));

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Sequences the writable instruction RAM that feeds the single-cycle core's fetch stage.
- Accepts a program as an 8-bit byte stream with a valid/ready handshake and packs each 3 bytes into one 22-bit instruction.
- Writes the instructions sequentially from word 0 while holding the core stalled, then pulses the core reset so execution restarts at PC 0.
- Outside a load, passes core fetches (byte address, word-aligned) straight through to the RAM read port.

Parameters:
DEPTH, 129, number of instruction words in the RAM.
WORD_W, 22, instruction width.
IDX_W, 8, RAM word-index width.
RST_CYCLES, 4, cycles cpu_rst_n is held low after a load.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
load_start  in  1  single-cycle pulse; begins a load (sampled only in IDLE/ERR).
word_count  in  IDX_W  number of words to load; sampled with load_start.
byte_valid  in  1  byte stream valid.
byte_data  in  8  byte stream data.
byte_ready  out  1  loader can accept a byte.
cpu_addr  in  22  core fetch byte address (PC).
cpu_instr  out  WORD_W  instruction returned to the core.
cpu_stall  out  1  holds the core PC/regfile writes.
cpu_rst_n  out  1  active-low reset to the core.
mem_raddr  out  IDX_W  RAM read index.
mem_rdata  in  WORD_W  RAM combinational read data.
mem_we  out  1  RAM write enable.
mem_waddr  out  IDX_W  RAM write index.
mem_wdata  out  WORD_W  RAM write data.
busy  out  1  load in progress (any state except IDLE/ERR).
done  out  1  sticky; last load completed.
error  out  1  sticky; last load_start had an illegal word_count.

Behaviour:
- Reset values (async on rst low): state IDLE, byte_ready 0, mem_we 0, mem_waddr 0, mem_wdata 0, cpu_stall 0, cpu_rst_n 1, busy 0, done 0, error 0, word index 0, byte shift register 0.
- States: IDLE, B0, B1, B2, WRITE, RELEASE, ERR.
- IDLE/ERR with load_start:
  - word_count==0 or word_count>DEPTH -> ERR, error=1, done=0.
  - Otherwise -> B0: latch count, index=0, done=0, error=0.
- load_start in any other state is ignored.
- B0/B1/B2:
  - byte_ready=1; a byte is accepted when byte_valid&&byte_ready.
  - Byte order is big-endian:
    - B0 byte[5:0] -> instr[21:16]; byte[7:6] discarded.
    - B1 byte -> instr[15:8].
    - B2 byte -> instr[7:0].
  - Without a handshake, remain in the current state.
- WRITE: exactly one cycle. mem_we=1, mem_waddr=index, mem_wdata=assembled word, byte_ready=0.
  - index==count-1 -> RELEASE.
  - Otherwise index+1 -> B0.
- RELEASE: cpu_rst_n=0 for RST_CYCLES cycles, byte_ready=0, then -> IDLE with done=1.
- cpu_stall=1 in B0, B1, B2, WRITE and RELEASE; 0 in IDLE and ERR.
- Throughput: best case 4 cycles per word (3 byte cycles + WRITE).
- Fetch path (combinational):
  - mem_raddr = cpu_addr[IDX_W+1:2].
  - cpu_instr = mem_rdata when cpu_stall==0 and cpu_addr[IDX_W+1:2] < DEPTH.
  - cpu_instr = 22'b0 otherwise (the stall/out-of-range NOP).
  - cpu_addr[1:0] and cpu_addr[21:IDX_W+2] are ignored.
- ERR: behaves as IDLE for fetches; error stays 1 until the next legal load_start.
- Reset mid-load: immediate return to IDLE with reset values. Words already written remain in RAM. No partial word is written.
- The byte stream is never back-pressured in B0–B2. Bytes offered during WRITE or RELEASE are not accepted.

Test Plan:
- Reset, then drive cpu_addr=8 with mem_rdata=22'h26_0088 -> mem_raddr=2, cpu_instr=22'h26_0088, cpu_stall=0, busy=0.
- load_start with word_count=2, then bytes 26,80,88 and 26,81,09 with valid held high -> mem_we pulses at word 0 = 22'h268088 and word 1 = 22'h268109; byte 26's bits[7:6] discarded; cpu_rst_n low exactly 4 cycles; done=1 on return to IDLE 4+4+4 cycles later.
- Same load with byte_valid toggling 1/0 each cycle -> identical RAM writes, cpu_stall held high throughout, no extra mem_we.
- load_start with word_count=0, then with 130 -> ERR, error=1, cpu_stall=0, no mem_we; a legal load_start then clears error.
- Assert rst low after the second byte of word 1 in a 3-word load -> state IDLE, mem_we=0, cpu_stall=0, done=0; word 0 retained.
- cpu_addr=516 (index 129) while idle -> cpu_instr=0. load_start pulsed mid-load -> ignored, count unchanged.
